// File: rtl/load_align_split.sv
// rtl/load_align_split.sv - load data unit: aligned memory reads, boundary split, byte extract and extend
package load_align_split_pkg;
    typedef enum logic [1:0] {
        BYTE        = 2'd0,
        HALF_WORD   = 2'd1,
        WORD        = 2'd2,
        DOUBLE_WORD = 2'd3
    } mem_access_size_t;
endpackage

module load_align_split
    import load_align_split_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 64,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  mem_access_size_t  req_size_i,
    input  logic              req_zero_extnd_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    input  logic              mem_rsp_err_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              rsp_misalign_o
);
    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);
    localparam logic [4:0] B_BYTES = 5'(B);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [OFF_W-1:0]  off_q;
    mem_access_size_t  size_q;
    logic              zext_q;
    logic              cross_q;
    logic [DATA_W-1:0] lo_q;

    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_base;
    logic              req_cross;
    logic              req_illegal;

    always_comb begin
        req_off     = req_addr_i[OFF_W-1:0];
        req_base    = req_addr_i & {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
        req_cross   = (5'(req_off) + (5'd1 << req_size_i)) > B_BYTES;
        req_illegal = (DATA_W == 32) && (req_size_i == DOUBLE_WORD);
    end

    // Shift the {hi,lo} window down to the addressed byte, then sign/zero fill above the field.
    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] hi,
        input logic [DATA_W-1:0] lo,
        input logic [OFF_W-1:0]  off,
        input mem_access_size_t  sz,
        input logic              zext
    );
        logic [2*DATA_W-1:0] sh;
        logic [DATA_W-1:0]   res;
        logic                msb;
        int                  nbits;
        sh    = {hi, lo} >> {off, 3'b000};
        nbits = 8 << sz;
        msb   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) msb = sh[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < nbits) ? sh[i] : (!zext && msb);
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            req_ready_o     <= 1'b1;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= '0;
            rsp_err_o       <= 1'b0;
            rsp_misalign_o  <= 1'b0;
            base_q          <= '0;
            off_q           <= '0;
            size_q          <= BYTE;
            zext_q          <= 1'b0;
            cross_q         <= 1'b0;
            lo_q            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        base_q      <= req_base;
                        off_q       <= req_off;
                        size_q      <= req_size_i;
                        zext_q      <= req_zero_extnd_i;
                        cross_q     <= req_cross;
                        req_ready_o <= 1'b0;
                        if (req_illegal || (req_cross && !ALLOW_MISALIGN)) begin
                            state          <= RESP;
                            rsp_valid_o    <= 1'b1;
                            rsp_data_o     <= '0;
                            rsp_err_o      <= 1'b1;
                            rsp_misalign_o <= 1'b1;
                        end else begin
                            state           <= REQ_LO;
                            mem_req_valid_o <= 1'b1;
                            mem_req_addr_o  <= req_base;
                        end
                    end
                end
                REQ_LO: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (mem_rsp_valid_i) begin
                        lo_q <= mem_rsp_data_i;
                        if (mem_rsp_err_i) begin
                            state          <= RESP;
                            rsp_valid_o    <= 1'b1;
                            rsp_data_o     <= '0;
                            rsp_err_o      <= 1'b1;
                            rsp_misalign_o <= 1'b0;
                        end else if (cross_q) begin
                            state           <= REQ_HI;
                            mem_req_valid_o <= 1'b1;
                            mem_req_addr_o  <= base_q + ADDR_W'(B);
                        end else begin
                            state          <= RESP;
                            rsp_valid_o    <= 1'b1;
                            rsp_data_o     <= extract('0, mem_rsp_data_i, off_q, size_q, zext_q);
                            rsp_err_o      <= 1'b0;
                            rsp_misalign_o <= 1'b0;
                        end
                    end
                end
                REQ_HI: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // The hi beat feeds the merge directly; lo_q holds the first beat.
                    if (mem_rsp_valid_i) begin
                        state          <= RESP;
                        rsp_valid_o    <= 1'b1;
                        rsp_misalign_o <= 1'b0;
                        if (mem_rsp_err_i) begin
                            rsp_data_o <= '0;
                            rsp_err_o  <= 1'b1;
                        end else begin
                            rsp_data_o <= extract(mem_rsp_data_i, lo_q, off_q, size_q, zext_q);
                            rsp_err_o  <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state          <= IDLE;
                        rsp_valid_o    <= 1'b0;
                        rsp_data_o     <= '0;
                        rsp_err_o      <= 1'b0;
                        rsp_misalign_o <= 1'b0;
                        req_ready_o    <= 1'b1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    req_ready_o     <= 1'b1;
                    mem_req_valid_o <= 1'b0;
                    rsp_valid_o     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/load_align_split.md
Name: load_align_split

Overview:
- Sequential load-data unit between the LSU issue stage and the data-memory port.
- Accepts one load request, issues one or two aligned memory reads, extracts the addressed bytes, and returns a sign- or zero-extended result.
- Misaligned loads that cross a DATA_W boundary are split into two beats and merged.
- Parametrised in data width and in whether misaligned loads are serviced or faulted.

Parameters:
DATA_W, 64, memory/result data width in bits; legal values 32 or 64
ADDR_W, 64, address width in bits
ALLOW_MISALIGN, 1, 1 = split boundary-crossing loads; 0 = return misaligned error without memory access

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  load request valid
req_ready_o  out  1  unit can accept a request
req_addr_i  in  ADDR_W  byte address
req_size_i  in  mem_access_size_t  BYTE/HALF_WORD/WORD/DOUBLE_WORD
req_zero_extnd_i  in  1  1 = zero-extend, 0 = sign-extend
mem_req_valid_o  out  1  memory read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_W  DATA_W/8-aligned read address
mem_rsp_valid_i  in  1  memory read data valid (always accepted)
mem_rsp_data_i  in  DATA_W  read data
mem_rsp_err_i  in  1  access fault on this beat
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  consumer accepts result
rsp_data_o  out  DATA_W  aligned, extended load result
rsp_err_o  out  1  fault on this result; rsp_data_o = 0 when set
rsp_misalign_o  out  1  error caused by misalignment or illegal size (valid with rsp_err_o)

Behaviour:
- Reset and ownership:
  - Reset: state IDLE; req_ready_o=1 in IDLE; mem_req_valid_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, rsp_misalign_o=0.
  - A synchronous reset in any state aborts the operation and returns to IDLE. mem_rsp_valid_i seen in IDLE or RESP is ignored.
- Definitions:
  - B = DATA_W/8; off = addr[log2(B)-1:0]; n = size in bytes (1/2/4/8).
  - cross = (off + n > B).
  - illegal = (DATA_W==32 and size==DOUBLE_WORD).
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr/size/zero_extnd, then:
    - if illegal, or (cross and !ALLOW_MISALIGN): go to RESP with rsp_err_o=1, rsp_misalign_o=1, and no memory access;
    - otherwise go to REQ_LO.
- REQ_LO:
  - mem_req_valid_o=1, mem_req_addr_o = addr with low log2(B) bits cleared.
  - Hold address until mem_req_ready_i; then go to WAIT_LO.
- WAIT_LO:
  - On mem_rsp_valid_i, store data in lo buffer.
  - If mem_rsp_err_i: go to RESP with rsp_err_o=1, rsp_misalign_o=0.
  - Else if cross: go to REQ_HI. Else: go to RESP.
- REQ_HI: mem_req_addr_o = aligned addr + B (wraps modulo 2^ADDR_W); handshake as in REQ_LO; then go to WAIT_HI.
- WAIT_HI:
  - On mem_rsp_valid_i, store data in hi buffer.
  - A fault gives rsp_err_o=1; in every case go to RESP.
- Merge (registered on entry to RESP):
  - Form {hi,lo} (hi=0 for a single beat) and shift right by off*8.
  - Take the low n bytes; bits above are filled with (!zero_extnd & msb of extracted field).
  - DOUBLE_WORD at DATA_W=64 copies the field unchanged.
- RESP:
  - rsp_valid_o=1 with data and flags held stable until rsp_ready_i; then go to IDLE.
  - req_ready_o=0; no bypass from RESP to a new request in the same cycle.
- Latency with mem_req_ready_i=1 and one-cycle memory:
  - aligned load: rsp_valid_o 3 cycles after accept;
  - split load: 5 cycles after accept.
- At most one operation is in flight.
- Exactly one mem_req handshake per beat; no request is issued after an error.

Test Plan:
- Aligned WORD, DATA_W=64, addr=0x1004, sign-extend, mem returns 0x80000001_00000000 -> one mem read at 0x1000; rsp_data_o=0xFFFFFFFF_80000001, err=0.
- Split HALF_WORD, addr=0x2007, zero-extend, lo beat 0xAB00_0000_0000_0000, hi beat 0x0000_0000_0000_00CD -> reads at 0x2000 then 0x2008; rsp_data_o=0x0000_0000_0000_CDAB.
- ALLOW_MISALIGN=0, WORD at 0x3006 -> no mem_req_valid_o; rsp_valid_o with rsp_err_o=1, rsp_misalign_o=1, data 0.
- Split DOUBLE_WORD at 0x4003 with mem_rsp_err_i=1 on the lo beat -> no hi request; rsp_err_o=1, rsp_misalign_o=0, data 0.
- Backpressure: mem_req_ready_i low 3 cycles and rsp_ready_i low 4 cycles -> address and result held stable, req_ready_o=0 throughout, single handshake each.
- rst pulsed during WAIT_HI, late mem_rsp_valid_i arrives after reset -> IDLE, all outputs 0, late data ignored; the next BYTE load at 0x5001 returns the correct byte.
